fmul_norm_round: RTL and testbench
==================================

FMUL_NORM_ROUND -- requirements
Module: fmul_norm_round

Interface
Parameters (name, default, meaning)
REQ-001 The block SHALL have parameter WIDTH, default 32: total result width.
REQ-002 The block SHALL have parameter EXP_WIDTH, default 8: exponent field width.
REQ-003 The block SHALL have parameter MAN_WIDTH, default 23: stored fraction width.
REQ-004 The block SHALL have parameter BIAS, default 127: exponent bias.

Ports (name, direction, width, meaning)
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1: upstream multiplier front-end offers a raw product.
REQ-008 The block SHALL have port in_ready, output, 1: block accepts the offer this cycle.
REQ-009 The block SHALL have port in_sign, input, 1: result sign, sign_a XOR sign_b.
REQ-010 The block SHALL have port in_exp, input, EXP_WIDTH+2: signed two's-complement value exp_a+exp_b-BIAS.
REQ-011 The block SHALL have port in_man, input, 2*MAN_WIDTH+2: unrounded significand product, with hidden bits included.
REQ-012 The block SHALL have port in_zero, input, 1: an operand is zero.
REQ-013 The block SHALL have port in_inf, input, 1: an operand is infinity.
REQ-014 The block SHALL have port in_nan, input, 1: an operand is NaN.
REQ-015 The block SHALL have port out_valid, output, 1: out_result and out_flags are valid.
REQ-016 The block SHALL have port out_ready, input, 1: downstream consumes the result.
REQ-017 The block SHALL have port out_result, output, WIDTH: packed IEEE-754 product.
REQ-018 The block SHALL have port out_flags, output, 4: {invalid, overflow, underflow, inexact}.

Function
REQ-019 Transfers SHALL occur only on valid&&ready, on both sides.
REQ-020 The datapath SHALL be two register stages: S1 normalize, S2 round+pack.
REQ-021 Latency SHALL be 2 cycles from input transfer to out_valid.
REQ-022 Throughput SHALL be 1 result/cycle while out_ready=1.
REQ-023 S1 SHALL advance when S2 is empty or S2 transfers; in_ready SHALL equal !s1_valid || s1_advance (combinational, no extra buffer).
REQ-024 While out_valid=1 and out_ready=0, out_result and out_flags SHALL remain stable.
REQ-025 S1: if in_man MSB=1, the significand SHALL shift right 1 and the exponent SHALL increment by 1; otherwise no shift.
REQ-026 S1 SHALL extract guard, round and sticky bits (sticky = OR of all lower bits).
REQ-027 S2 SHALL round to nearest, ties to even: increment if G && (R || S || LSB).
REQ-028 A rounding carry-out SHALL increment the exponent and zero the fraction.
REQ-029 inexact SHALL equal G|R|S of the final alignment.
REQ-030 Overflow: a final exponent >= 2^EXP_WIDTH-1 SHALL give signed infinity with overflow=1 and inexact=1.
REQ-031 Underflow: handling of a final exponent <= 0 SHALL follow the Configuration section.
REQ-032 Specials priority SHALL be: (1) in_nan, or in_inf && in_zero, gives 0x7FC00000 with invalid=1; (2) in_inf gives signed infinity; (3) in_zero gives signed zero.
REQ-033 Special results SHALL carry no other flags.

Reset
REQ-034 rst SHALL clear s1_valid and s2_valid, so out_valid=0 and in_ready=1 the next cycle.
REQ-035 rst SHALL set out_result=0 and out_flags=0.
REQ-036 An in-flight operation SHALL be discarded on rst, with no partial output.
REQ-037 rst SHALL take priority over a simultaneous in_valid.

Configuration
REQ-038 With macro FMUL_NR_SUBNORMAL_EN defined, an exponent <= 0 SHALL shift the significand right by 1-exp (saturated at MAN_WIDTH+3) into G/R/S, then round, and the packed exponent SHALL be 0 (1 if rounding reaches the hidden bit).
REQ-039 With FMUL_NR_SUBNORMAL_EN defined, underflow SHALL equal tiny && inexact.
REQ-040 Without FMUL_NR_SUBNORMAL_EN, an exponent <= 0 SHALL flush to signed zero with underflow=1 and inexact=1.

Structure
REQ-041 Package fpu_pkg SHALL hold the flag index constants (FLG_INVALID..FLG_INEXACT), the canonical qNaN constant and the S1-to-S2 struct typedef (sign, exp, man, grs, special code).
REQ-042 The round-and-pack logic SHALL be a sub-module fmul_round_pack, instantiated in S2.

Verification
REQ-043 Normalize: in_exp=127, in_man=1<<47 (2.0) SHALL give 0x40000000 after 2 cycles, flags 0.
REQ-044 Tie-even: in_exp=127, in_man bit46=1, bit22=1 SHALL give 0x3F800000, inexact=1; adding bit23=1 SHALL give 0x3F800002.
REQ-045 Overflow: in_exp=255, in_man=1<<46 SHALL give 0x7F800000, flags=0b0101.
REQ-046 Special: in_inf=1 and in_zero=1 SHALL give 0x7FC00000, flags=0b1000; in_inf=1, in_sign=1 SHALL give 0xFF800000.
REQ-047 Backpressure: out_ready=0 for 4 cycles with 3 back-to-back offers SHALL accept 2, drop in_ready, lose no data, and emit results in order once out_ready=1.
REQ-048 Reset mid-flight: rst with both stages full SHALL give out_valid=0 on the next cycle, and no stale result SHALL appear afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: flag bit positions, the canonical quiet NaN and the record that
// carries a normalized product from the S1 register into round-and-pack.
package fpu_pkg;

  // Field widths the S1-to-S2 record is built for (IEEE-754 binary32).
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}.
  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  // Canonical quiet NaN returned for every invalid operation.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Special-operand class resolved in S1, already in priority order.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } special_e;

  // Normalized product handed from S1 to S2.
  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W+1:0] exp;      // two's complement, after normalization
    logic [FP_MAN_W:0]   man;      // hidden bit + fraction, truncated
    logic [2:0]          grs;      // guard, round, sticky
    special_e            special;
  } s1_data_t;

endpackage

// File: rtl/fmul_round_pack.sv
// fmul_round_pack: round-to-nearest-even, exponent range handling and
// IEEE-754 packing of one normalized product. Purely combinational; the
// caller registers the result.
// Optional feature: define FMUL_NR_SUBNORMAL_EN to produce subnormal results
// instead of flushing tiny results to signed zero.
module fmul_round_pack
  import fpu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  s1_data_t         d_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int XW = EXP_WIDTH + 2;
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_WIDTH) - 1);

  logic signed [XW-1:0] exp_s;
  logic signed [XW-1:0] exp_r;
  logic                 g, r, s;
  logic                 inexact;
  logic                 inc;
  logic                 carry;
  logic [MAN_WIDTH+1:0] rnd;

  // Round the significand, then choose special / tiny / overflow / normal packing.
  always_comb begin
    exp_s    = $signed(d_i.exp);
    {g, r, s} = d_i.grs;
    inexact  = g | r | s;
    inc      = g & (r | s | d_i.man[0]);
    rnd      = {1'b0, d_i.man} + {{(MAN_WIDTH+1){1'b0}}, inc};
    // A carry out of the hidden bit means the significand became 2.0.
    carry    = rnd[MAN_WIDTH+1];
    exp_r    = exp_s + {{(XW-1){1'b0}}, carry};
    result_o = '0;
    flags_o  = '0;
    case (d_i.special)
      SP_NAN: begin
        result_o              = WIDTH'(QNAN);
        flags_o[FLG_INVALID]  = 1'b1;
      end
      SP_INF: begin
        result_o = {d_i.sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      end
      SP_ZERO: begin
        result_o = {d_i.sign, {(WIDTH-1){1'b0}}};
      end
      default: begin
        if (exp_s <= EXP_ZERO) begin
`ifdef FMUL_NR_SUBNORMAL_EN
          // S1 already denormalized; rounding into the hidden bit yields exponent 1.
          result_o = {d_i.sign, {(EXP_WIDTH-1){1'b0}}, rnd[MAN_WIDTH], rnd[MAN_WIDTH-1:0]};
          flags_o[FLG_UNDERFLOW] = inexact;
          flags_o[FLG_INEXACT]   = inexact;
`else
          result_o = {d_i.sign, {(WIDTH-1){1'b0}}};
          flags_o[FLG_UNDERFLOW] = 1'b1;
          flags_o[FLG_INEXACT]   = 1'b1;
`endif
        end else if (exp_r >= EXP_MAX) begin
          result_o = {d_i.sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
          flags_o[FLG_OVERFLOW] = 1'b1;
          flags_o[FLG_INEXACT]  = 1'b1;
        end else begin
          result_o = {d_i.sign, exp_r[EXP_WIDTH-1:0],
                      carry ? {MAN_WIDTH{1'b0}} : rnd[MAN_WIDTH-1:0]};
          flags_o[FLG_INEXACT] = inexact;
        end
      end
    endcase
  end

endmodule

// File: rtl/fmul_norm_round.sv
// fmul_norm_round: back end of a floating-point multiplier. S1 normalizes the
// raw significand product and extracts guard/round/sticky; S2 holds the
// rounded, packed result from fmul_round_pack.
// Optional feature: define FMUL_NR_SUBNORMAL_EN for gradual underflow;
// by default tiny results flush to signed zero.
//
// Handshake: a transfer happens on a rising edge where valid && ready on the
// same side. in_ready is combinational (!s1_valid || S2 can accept); out_valid
// is registered and out_result/out_flags hold steady while out_ready is low.
module fmul_norm_round
  import fpu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int BIAS      = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_WIDTH+1:0]   in_exp,
  input  logic [2*MAN_WIDTH+1:0] in_man,
  input  logic                   in_zero,
  input  logic                   in_inf,
  input  logic                   in_nan,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [3:0]             out_flags
);

  localparam int PW = 2 * MAN_WIDTH + 2;   // raw product width
  localparam int SW = MAN_WIDTH + 1;       // kept significand width
  localparam int XW = EXP_WIDTH + 2;       // signed exponent width

  // The S1 record is laid out for the package widths; reject other shapes.
  if (WIDTH != 1 + EXP_WIDTH + MAN_WIDTH || EXP_WIDTH != FP_EXP_W ||
      MAN_WIDTH != FP_MAN_W || BIAS != (1 << (EXP_WIDTH - 1)) - 1) begin : g_param_check
    $error("fmul_norm_round: unsupported parameter combination");
  end

  logic             s1_valid_q, s1_valid_d;
  s1_data_t         s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flg_q, flg_d;

  logic             s1_advance;
  logic             in_fire;
  logic [WIDTH-1:0] rp_result;
  logic [3:0]       rp_flags;

  s1_data_t             norm;
  logic                 msb;
  logic [PW-1:0]        norm_man;
  logic signed [XW-1:0] exp_n;
  logic [SW-1:0]        sig;
  logic [2:0]           grs;

`ifdef FMUL_NR_SUBNORMAL_EN
  localparam int SAT = MAN_WIDTH + 3;      // shifts beyond this leave only sticky
  localparam int DW  = PW + SAT;
  localparam int AW  = $clog2(SAT + 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW:0]   SAT_X    = (XW+1)'(SAT);
  localparam logic signed [XW:0]   ONE_X    = (XW+1)'(1);
  logic signed [XW:0] sh_w;
  logic [AW-1:0]      amt;
  logic [DW-1:0]      dn;
`endif

  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_flags  = flg_q;

  // S1 combinational: align hidden bit to the top, split off G/R/S, classify specials.
  always_comb begin
    msb      = in_man[PW-1];
    norm_man = msb ? in_man : {in_man[PW-2:0], 1'b0};
    exp_n    = $signed(in_exp) + $signed({{(XW-1){1'b0}}, msb});
    sig      = norm_man[PW-1 -: SW];
    grs      = {norm_man[PW-SW-1], norm_man[PW-SW-2], |norm_man[PW-SW-3:0]};
`ifdef FMUL_NR_SUBNORMAL_EN
    sh_w = '0;
    amt  = '0;
    dn   = '0;
    if (exp_n <= EXP_ZERO) begin
      // Denormalize by 1-exp; the zero-padded tail keeps every shifted-out bit.
      sh_w = ONE_X - {exp_n[XW-1], exp_n};
      amt  = (sh_w > SAT_X) ? AW'(SAT) : sh_w[AW-1:0];
      dn   = {norm_man, {SAT{1'b0}}} >> amt;
      sig  = dn[DW-1 -: SW];
      grs  = {dn[DW-SW-1], dn[DW-SW-2], |dn[DW-SW-3:0]};
    end
`endif
    norm.sign = in_sign;
    norm.exp  = exp_n;
    norm.man  = sig;
    norm.grs  = grs;
    if (in_nan || (in_inf && in_zero)) norm.special = SP_NAN;
    else if (in_inf)                   norm.special = SP_INF;
    else if (in_zero)                  norm.special = SP_ZERO;
    else                               norm.special = SP_NONE;
  end

  // S2 round-and-pack of the S1 register contents.
  fmul_round_pack #(
    .WIDTH     (WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_round_pack (
    .d_i      (s1_q),
    .result_o (rp_result),
    .flags_o  (rp_flags)
  );

  // Next-state for both stages: load on transfer, otherwise hold.
  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_d       = in_fire ? norm : s1_q;
    s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;
    res_d      = res_q;
    flg_d      = flg_q;
    if (s1_advance && s1_valid_q) begin
      res_d = rp_result;
      flg_d = rp_flags;
    end
  end

  // Pipeline registers; reset discards in-flight work and wins over any offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

endmodule

// File: tb/tb_fmul_norm_round.sv
// tb_fmul_norm_round: randomized and directed stimulus for fmul_norm_round,
// scored against an arithmetic model of normalize + round-nearest-even.
module tb_fmul_norm_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_man;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];   // {flags, result}
  logic rand_phase;

  fmul_norm_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_man     (in_man),
    .in_zero    (in_zero),
    .in_inf     (in_inf),
    .in_nan     (in_nan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Exact product value man * 2^(exp-BIAS-46), rounded to nearest-even.
  function automatic logic [35:0] model(input logic s, input logic [9:0] e,
                                        input logic [47:0] m, input logic z,
                                        input logic inf, input logic nan);
    int ee;
    int d;
    longint unsigned mm, q, rem, half;
    logic inx;
    if (nan || (inf && z)) return {4'b1000, 32'h7FC0_0000};
    if (inf)               return {4'b0000, s, 8'hFF, 23'h0};
    if (z)                 return {4'b0000, s, 31'h0};
    mm = 64'(m);
    ee = int'($signed(e));
    d  = 23;                               // bits below the kept 24-bit significand
    if (m[47]) begin
      d  = 24;
      ee = ee + 1;
    end
    if (ee <= 0) begin
`ifdef FMUL_NR_SUBNORMAL_EN
      d = d + (((1 - ee) > 26) ? 26 : (1 - ee));
`else
      return {4'b0011, s, 31'h0};
`endif
    end
    q    = mm >> d;
    rem  = mm & ((64'd1 << d) - 64'd1);
    half = 64'd1 << (d - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    inx = (rem != 0);
    if (ee <= 0)
      return {2'b00, inx, inx, s, (q >= 64'd8388608) ? 8'd1 : 8'd0, q[22:0]};
    if (q == 64'd16777216) begin
      q  = 64'd8388608;
      ee = ee + 1;
    end
    if (ee >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    return {3'b000, inx, s, ee[7:0], q[22:0]};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h/%h want no output", out_flags, out_result);
        end else begin
          check("out", {28'h0, out_flags, out_result}, {28'h0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sign, in_exp, in_man, in_zero, in_inf, in_nan));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m,
                       input logic z, input logic inf, input logic nan);
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    in_zero  = z;
    in_inf   = inf;
    in_nan   = nan;
    in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                      input logic z, input logic inf, input logic nan);
    drive(s, e, m, z, inf, nan);
    wait_accept();
  endtask

  task automatic send_random();
    logic [63:0] r64;
    logic [47:0] m;
    int ev, k;
    r64 = {$urandom(), $urandom()};
    m   = r64[47:0];
    if ($urandom_range(0, 1) == 1) m[47] = 1'b1;
    else m[47:46] = 2'b01;
    k = $urandom_range(0, 99);
    if (k < 10) begin
      m[21:0] = 22'h0;                    // tie when no top bit
      m[22]   = 1'b1;
    end else if (k < 20) begin
      m[22:0] = 23'h0;                    // tie when top bit set
      m[23]   = 1'b1;
    end else if (k < 25) begin
      m[46:0] = {47{1'b1}};               // rounding carry-out
    end
    k = $urandom_range(0, 99);
    if (k < 55)      ev = $urandom_range(1, 254);
    else if (k < 75) ev = int'($urandom_range(0, 40)) - 30;
    else if (k < 95) ev = $urandom_range(245, 262);
    else             ev = int'($urandom_range(0, 500)) - 150;
    send($urandom_range(0, 1) == 1, ev[9:0], m,
         $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
         $urandom_range(0, 29) == 0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sign    = 1'b0;
    in_exp     = '0;
    in_man     = '0;
    in_zero    = 1'b0;
    in_inf     = 1'b0;
    in_nan     = 1'b0;
    out_ready  = 1'b1;
    rand_phase = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_flags", 64'(out_flags), 64'd0);

    // Hand-computed values pinning the model.
    check("pin_norm", 64'(model(0, 10'd127, 48'h8000_0000_0000, 0, 0, 0)), 64'h0_4000_0000);
    check("pin_tie_even", 64'(model(0, 10'd127, 48'h4000_0040_0000, 0, 0, 0)), 64'h1_3F80_0000);
    check("pin_tie_odd", 64'(model(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0)), 64'h1_3F80_0002);
    check("pin_ovf", 64'(model(0, 10'd255, 48'h4000_0000_0000, 0, 0, 0)), 64'h5_7F80_0000);
    check("pin_inv", 64'(model(0, 10'd127, 48'h4000_0000_0000, 1, 1, 0)), 64'h8_7FC0_0000);
    check("pin_neg_inf", 64'(model(1, 10'd127, 48'h4000_0000_0000, 0, 1, 0)), 64'h0_FF80_0000);
    check("pin_carry", 64'(model(0, 10'd127, 48'h7FFF_FFFF_FFFF, 0, 0, 0)), 64'h1_4000_0000);
`ifdef FMUL_NR_SUBNORMAL_EN
    check("pin_tiny", 64'(model(1, 10'd0, 48'h4000_0000_0000, 0, 0, 0)), 64'h0_8040_0000);
`else
    check("pin_tiny", 64'(model(1, 10'd0, 48'h4000_0000_0000, 0, 0, 0)), 64'h3_8000_0000);
`endif

    // Latency: accepted on edge 1, visible after edge 2.
    @(posedge clk);
    #1;
    drive(0, 10'd127, 48'h8000_0000_0000, 0, 0, 0);
    @(negedge clk);
    check("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2", 64'(out_valid), 64'd1);

    // Directed cases, scored by the compare process.
    @(posedge clk);
    #1;
    send(0, 10'd127, 48'h4000_0040_0000, 0, 0, 0);
    send(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0);
    send(0, 10'd255, 48'h4000_0000_0000, 0, 0, 0);
    send(0, 10'd127, 48'h4000_0000_0000, 1, 1, 0);
    send(1, 10'd127, 48'h4000_0000_0000, 0, 1, 0);
    send(1, 10'd0, 48'h4000_0000_0000, 0, 0, 0);
    send(0, 10'h3F0, 48'hC123_4567_89AB, 0, 0, 0);
    send(0, 10'd127, 48'h7FFF_FFFF_FFFF, 0, 0, 0);
    drain();

    // Backpressure: two accepted, third held off until the output drains.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, 10'd100, 48'h5555_5555_5555, 0, 0, 0);
    send(1, 10'd140, 48'hAAAA_AAAA_AAAA, 0, 0, 0);
    drive(0, 10'd127, 48'h6000_0000_0001, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    check("bp_queued", 64'(exp_q.size()), 64'd2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Randomized traffic with random output stalls.
    rand_phase = 1'b1;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          send_random();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    drain();

    // Reset with both stages full.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, 10'd130, 48'h8888_0000_0000, 0, 0, 0);
    send(1, 10'd120, 48'h4444_0000_0000, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_result", {28'h0, out_flags, out_result}, 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mid_rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
